// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU control decode and load-use bubble insertion
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic          exmem_wr_en,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_wr_en,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_opcode,
  output logic          alu_cin,
  output logic          alu_inv2,
  output logic [2:0]    flag_en,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [RW-1:0] ex_rd_addr,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_hazard
);
  localparam logic [DW-1:0] M_FFFE = DW'(16'hFFFE);
  localparam logic [DW-1:0] M_FF00 = DW'(16'hFF00);
  localparam logic [DW-1:0] M_00FF = DW'(16'h00FF);
  logic          r_valid, r_reg_write, r_mem_read, r_mem_write, r_cin, r_inv2;
  logic [2:0]    r_alu_op, r_flag_en;
  logic [3:0]    r_op;
  logic [RW-1:0] r_rs_addr, r_rt_addr, r_rd;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
  logic          w_uses_rt, w_writes, w_bubble;
  logic [DW-1:0] w_rs, w_rt;
  // rt is a source for R-type ALU ops, SW (store data) and LLB/LHB (old rd value)
  assign w_uses_rt = !id_opcode[3] ? (!id_opcode[2] || &id_opcode[2:0])
                                   : (id_opcode[3:2] == 2'b10 && id_opcode[1:0] != 2'b00);
  assign w_writes  = !id_opcode[3] || (id_opcode[3:2] == 2'b10 && id_opcode[1:0] != 2'b01);
  assign load_use_hazard = r_valid && r_mem_read && r_rd != '0 && id_valid &&
                           (id_rs_addr == r_rd || (w_uses_rt && id_rt_addr == r_rd));
  // Invalid slots and load-use conflicts both turn into an all-zero bubble unless stalled
  assign w_bubble = flush || (!stall && (load_use_hazard || !id_valid));
  // Pipeline register: reset, then flush/bubble, stall hold, else capture decoded ID fields
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_cin       <= 1'b0;
      r_inv2      <= 1'b0;
      r_alu_op    <= '0;
      r_flag_en   <= '0;
      r_op        <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_reg_write <= w_writes && id_rd_addr != '0;
      r_mem_read  <= id_opcode == 4'b1000;
      r_mem_write <= id_opcode == 4'b1001;
      r_cin       <= id_opcode == 4'b0001;
      r_inv2      <= id_opcode == 4'b0001;
      r_alu_op    <= id_opcode[3] ? 3'b000 : id_opcode[2:0];
      r_flag_en   <= id_opcode[3:1] == 3'b000 ? 3'b111 :
                     (id_opcode == 4'b0010 || (id_opcode[3:2] == 2'b01 && id_opcode[1:0] != 2'b11)) ? 3'b100 : 3'b000;
      r_op        <= id_opcode;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd        <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
    end
  end
  // EX/MEM beats MEM/WB; R0 never forwards
  assign w_rs = (exmem_wr_en && r_rs_addr != '0 && exmem_rd == r_rs_addr) ? exmem_data :
                (memwb_wr_en && r_rs_addr != '0 && memwb_rd == r_rs_addr) ? memwb_data : r_rs_data;
  assign w_rt = (exmem_wr_en && r_rt_addr != '0 && exmem_rd == r_rt_addr) ? exmem_data :
                (memwb_wr_en && r_rt_addr != '0 && memwb_rd == r_rt_addr) ? memwb_data : r_rt_data;
  // Masks are applied after forwarding so a forwarded base/old-rd value is still shaped correctly
  assign alu_in1 = !r_op[3] ? w_rs :
                   r_op[2]  ? '0 :
                   !r_op[1] ? (w_rs & M_FFFE) :
                   r_op[0]  ? (w_rt & M_00FF) : (w_rt & M_FF00);
  assign alu_in2 = !r_op[3] ? ((r_op[2] && !(&r_op[1:0])) ? r_imm : w_rt) :
                   r_op[2]  ? '0 :
                   !r_op[1] ? r_imm :
                   r_op[0]  ? (r_imm & M_FF00) : (r_imm & M_00FF);
  assign alu_opcode    = r_alu_op;
  assign alu_cin       = r_cin;
  assign alu_inv2      = r_inv2;
  assign flag_en       = r_flag_en;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_rd_addr    = r_rd;
  assign ex_store_data = w_rt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors checked against an instruction-level model of the ID/EX stage
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  logic clk, rst_n, stall, flush, id_valid;
  logic [3:0] id_opcode;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic exmem_wr_en, memwb_wr_en;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_data, memwb_data;
  logic [DW-1:0] alu_in1, alu_in2, ex_store_data;
  logic [2:0] alu_opcode, flag_en;
  logic alu_cin, alu_inv2, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [RW-1:0] ex_rd_addr;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_inv2(alu_inv2), .flag_en(flag_en), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit run = 0;

  // Model state: the instruction currently sitting in EX (all-zero = bubble)
  logic m_v = 0;
  logic [3:0] m_op = 0, m_rs = 0, m_rt = 0, m_rd = 0;
  logic [15:0] m_rsd = 0, m_rtd = 0, m_imm = 0;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] a, input logic [15:0] d);
    if (exmem_wr_en && a != 0 && exmem_rd == a) return exmem_data;
    if (memwb_wr_en && a != 0 && memwb_rd == a) return memwb_data;
    return d;
  endfunction

  function automatic logic exp_haz();
    logic uses;
    uses = id_opcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd10, 4'd11};
    return m_v && m_op == 4'd8 && m_rd != 0 && id_valid &&
           (id_rs_addr == m_rd || (uses && id_rt_addr == m_rd));
  endfunction

  // Model register update
  always @(posedge clk) begin
    logic hz;
    hz = exp_haz();
    if (!rst_n || flush || (!stall && (hz || !id_valid))) begin
      m_v = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
    end else if (!stall) begin
      m_v = 1; m_op = id_opcode; m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [15:0] rs, rt, e1, e2;
    logic [2:0] eop, efe;
    logic ec, ei, erw, emr, emw;
    if (run) begin
      rs = fwd(m_rs, m_rsd);
      rt = fwd(m_rt, m_rtd);
      e1 = 0; e2 = 0; eop = 0; efe = 0; ec = 0; ei = 0; erw = 0; emr = 0; emw = 0;
      if (m_v) case (m_op)
        0:       begin e1 = rs; e2 = rt; efe = 3'b111; erw = 1; end
        1:       begin e1 = rs; e2 = rt; eop = 1; ec = 1; ei = 1; efe = 3'b111; erw = 1; end
        2:       begin e1 = rs; e2 = rt; eop = 2; efe = 3'b100; erw = 1; end
        3:       begin e1 = rs; e2 = rt; eop = 3; erw = 1; end
        7:       begin e1 = rs; e2 = rt; eop = 7; erw = 1; end
        4, 5, 6: begin e1 = rs; e2 = m_imm; eop = m_op[2:0]; efe = 3'b100; erw = 1; end
        8:       begin e1 = rs & 16'hFFFE; e2 = m_imm; emr = 1; erw = 1; end
        9:       begin e1 = rs & 16'hFFFE; e2 = m_imm; emw = 1; end
        10:      begin e1 = rt & 16'hFF00; e2 = m_imm & 16'h00FF; erw = 1; end
        11:      begin e1 = rt & 16'h00FF; e2 = m_imm & 16'hFF00; erw = 1; end
        default: ;
      endcase
      if (m_rd == 0) erw = 0;
      chk("m_in1", alu_in1, e1);
      chk("m_in2", alu_in2, e2);
      chk("m_aop", 16'(alu_opcode), 16'(eop));
      chk("m_cin", 16'(alu_cin), 16'(ec));
      chk("m_inv2", 16'(alu_inv2), 16'(ei));
      chk("m_flag", 16'(flag_en), 16'(efe));
      chk("m_valid", 16'(ex_valid), 16'(m_v));
      chk("m_rw", 16'(ex_reg_write), 16'(erw));
      chk("m_mr", 16'(ex_mem_read), 16'(emr));
      chk("m_mw", 16'(ex_mem_write), 16'(emw));
      chk("m_rd", 16'(ex_rd_addr), 16'(m_rd));
      chk("m_store", ex_store_data, rt);
      chk("m_haz", 16'(load_use_hazard), 16'(exp_haz()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic [15:0] imm);
    id_valid = 1; id_opcode = op; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    exmem_wr_en = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0;
    set_id(4'd0, 4'd1, 4'd2, 4'd3, 16'h0007, 16'h0009, 16'h0000);
    cyc(); run = 1; cyc();
    chk("reset_in1", alu_in1, 16'h0000);
    chk("reset_valid", 16'(ex_valid), 16'h0);
    chk("reset_rw", 16'(ex_reg_write), 16'h0);
    chk("reset_haz", 16'(load_use_hazard), 16'h0);
    rst_n = 1;
    set_id(4'd1, 4'd1, 4'd2, 4'd3, 16'h0005, 16'h0003, 16'h0000);
    cyc();
    chk("sub_in1", alu_in1, 16'h0005);
    chk("sub_in2", alu_in2, 16'h0003);
    chk("sub_aop", 16'(alu_opcode), 16'h1);
    chk("sub_cin", 16'(alu_cin), 16'h1);
    chk("sub_inv2", 16'(alu_inv2), 16'h1);
    chk("sub_flag", 16'(flag_en), 16'h7);
    chk("sub_rw", 16'(ex_reg_write), 16'h1);
    set_id(4'd0, 4'd1, 4'd2, 4'd3, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    exmem_wr_en = 1; exmem_rd = 1; exmem_data = 16'h00AA;
    memwb_wr_en = 1; memwb_rd = 1; memwb_data = 16'h0055;
    #1 chk("fwd_exmem", alu_in1, 16'h00AA);
    exmem_wr_en = 0;
    #1 chk("fwd_memwb", alu_in1, 16'h0055);
    set_id(4'd0, 4'd0, 4'd2, 4'd3, 16'h0000, 16'h0000, 16'h0000);
    exmem_wr_en = 1; exmem_rd = 0; memwb_rd = 0;
    cyc();
    chk("fwd_r0", alu_in1, 16'h0000);
    exmem_wr_en = 0; memwb_wr_en = 0;
    set_id(4'd8, 4'd1, 4'd0, 4'd4, 16'h0103, 16'h0000, 16'h0010);
    cyc();
    chk("lw_in1", alu_in1, 16'h0102);
    chk("lw_in2", alu_in2, 16'h0010);
    chk("lw_mr", 16'(ex_mem_read), 16'h1);
    set_id(4'd0, 4'd4, 4'd6, 4'd5, 16'h1111, 16'h0002, 16'h0000);
    #1 chk("lu_haz", 16'(load_use_hazard), 16'h1);
    cyc();
    chk("lu_bubble_valid", 16'(ex_valid), 16'h0);
    chk("lu_bubble_flag", 16'(flag_en), 16'h0);
    chk("lu_haz_clear", 16'(load_use_hazard), 16'h0);
    memwb_wr_en = 1; memwb_rd = 4; memwb_data = 16'hBEEF;
    cyc();
    chk("lu_issue_in1", alu_in1, 16'hBEEF);
    chk("lu_issue_in2", alu_in2, 16'h0002);
    chk("lu_issue_valid", 16'(ex_valid), 16'h1);
    stall = 1;
    set_id(4'd2, 4'd9, 4'd9, 4'd9, 16'h0001, 16'h0001, 16'h0000);
    repeat (3) begin
      cyc();
      chk("stall_in1", alu_in1, 16'hBEEF);
      chk("stall_rd", 16'(ex_rd_addr), 16'h5);
      chk("stall_flag", 16'(flag_en), 16'h7);
    end
    flush = 1;
    cyc();
    chk("flush_valid", 16'(ex_valid), 16'h0);
    chk("flush_rw", 16'(ex_reg_write), 16'h0);
    stall = 0; flush = 0; memwb_wr_en = 0;
    set_id(4'd11, 4'd0, 4'd7, 4'd7, 16'h0000, 16'h1234, 16'hAB00);
    cyc();
    chk("lhb_in1", alu_in1, 16'h0034);
    chk("lhb_in2", alu_in2, 16'hAB00);
    chk("lhb_aop", 16'(alu_opcode), 16'h0);
    chk("lhb_flag", 16'(flag_en), 16'h0);
    set_id(4'd10, 4'd0, 4'd7, 4'd7, 16'h0000, 16'h1234, 16'h00CD);
    cyc();
    chk("llb_in1", alu_in1, 16'h1200);
    chk("llb_in2", alu_in2, 16'h00CD);
    set_id(4'd9, 4'd1, 4'd2, 4'd0, 16'h0011, 16'h3333, 16'h0004);
    exmem_wr_en = 1; exmem_rd = 2; exmem_data = 16'h7777;
    cyc();
    chk("sw_store", ex_store_data, 16'h7777);
    chk("sw_in1", alu_in1, 16'h0010);
    chk("sw_mw", 16'(ex_mem_write), 16'h1);
    chk("sw_rw", 16'(ex_reg_write), 16'h0);
    exmem_wr_en = 0;
    set_id(4'd5, 4'd1, 4'd0, 4'd6, 16'h8000, 16'h0000, 16'h0003);
    cyc();
    chk("sra_aop", 16'(alu_opcode), 16'h5);
    chk("sra_in2", alu_in2, 16'h0003);
    chk("sra_flag", 16'(flag_en), 16'h4);
    set_id(4'd12, 4'd1, 4'd2, 4'd3, 16'h0005, 16'h0006, 16'h0007);
    cyc();
    chk("op12_in1", alu_in1, 16'h0000);
    chk("op12_rw", 16'(ex_reg_write), 16'h0);
    chk("op12_valid", 16'(ex_valid), 16'h1);
    set_id(4'd0, 4'd1, 4'd2, 4'd0, 16'h0005, 16'h0006, 16'h0000);
    cyc();
    chk("rd0_rw", 16'(ex_reg_write), 16'h0);
    id_valid = 0;
    cyc();
    chk("invalid_valid", 16'(ex_valid), 16'h0);
    set_id(4'd8, 4'd1, 4'd0, 4'd4, 16'h0020, 16'h0000, 16'h0002);
    cyc();
    set_id(4'd0, 4'd4, 4'd6, 4'd5, 16'h0001, 16'h0002, 16'h0000);
    #1 chk("rst_haz_before", 16'(load_use_hazard), 16'h1);
    rst_n = 0;
    cyc();
    chk("rst_haz_after", 16'(load_use_hazard), 16'h0);
    chk("rst_valid", 16'(ex_valid), 16'h0);
    rst_n = 1;
    cyc();
    chk("post_rst_in1", alu_in1, 16'h0001);
    cyc();
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
